// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX-stage operand bypass selection plus ID-stage stall
// generation for load-use, pending multi-cycle writebacks and mul/div
// occupancy. A per-register pending scoreboard and an outstanding-op counter
// track multi-cycle ops between issue and completion.
// Optional build macro: FWD_HAZARD_STATS_EN adds three 32-bit event counters.
module fwd_hazard_unit #(
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned MC_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_SRC-1:0][REG_AW-1:0]   id_rs,
    input  logic [NUM_SRC-1:0]               id_rs_used,
    input  logic                             id_mc_issue,
    input  logic [REG_AW-1:0]                id_rd,
    input  logic [REG_AW-1:0]                id_ex_rd,
    input  logic                             id_ex_memread,
    input  logic [NUM_SRC-1:0][REG_AW-1:0]   ex_rs,
    input  logic [REG_AW-1:0]                ex_mem_rd,
    input  logic                             ex_mem_regwrite,
    input  logic [REG_AW-1:0]                mem_wb_rd,
    input  logic                             mem_wb_regwrite,
    input  logic                             mc_done,
    input  logic [REG_AW-1:0]                mc_done_rd,
    output logic [NUM_SRC-1:0][1:0]          fw_sel,
    output logic                             stall,
    output logic                             mc_busy
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [31:0]                      stat_stall_cyc,
    output logic [31:0]                      stat_fwd_cnt,
    output logic [31:0]                      stat_mc_fwd_cnt
`endif
);

    localparam int unsigned NUM_REGS = 1 << REG_AW;
    localparam int unsigned CNT_W    = $clog2(MC_DEPTH + 1);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_MC  = 2'b11;

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;
    logic [CNT_W-1:0]    mc_cnt;
    logic [CNT_W-1:0]    mc_cnt_nxt;

    logic load_use_c;
    logic pend_haz_c;
    logic waw_c;
    logic ovf_c;
    logic acc_issue_c;
    logic cnt_dec_c;

    // Per-operand bypass select; youngest producer wins, x0 never forwards
    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            fw_sel[i] = SEL_RF;
            if (ex_rs[i] != '0) begin
                if (ex_mem_regwrite && (ex_mem_rd == ex_rs[i])) begin
                    fw_sel[i] = SEL_MEM;
                end else if (mc_done && (mc_done_rd == ex_rs[i])) begin
                    fw_sel[i] = SEL_MC;
                end else if (mem_wb_regwrite && (mem_wb_rd == ex_rs[i])) begin
                    fw_sel[i] = SEL_WB;
                end
            end
        end
    end

    // Operand-driven stall terms: load-use and reads of pending registers
    always_comb begin
        load_use_c = 1'b0;
        pend_haz_c = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (id_rs_used[i]) begin
                if (id_ex_memread && (id_ex_rd != '0) && (id_ex_rd == id_rs[i])) begin
                    load_use_c = 1'b1;
                end
                if ((id_rs[i] != '0) && pending[id_rs[i]]
                    && !(mc_done && (mc_done_rd == id_rs[i]))) begin
                    pend_haz_c = 1'b1;
                end
            end
        end
    end

    // Issue-driven stall terms and the combined stall
    always_comb begin
        waw_c       = id_mc_issue && (id_rd != '0) && pending[id_rd]
                      && !(mc_done && (mc_done_rd == id_rd));
        ovf_c       = id_mc_issue && mc_busy && !mc_done;
        stall       = load_use_c | pend_haz_c | waw_c | ovf_c;
        acc_issue_c = id_mc_issue & ~stall;
    end

    // Scoreboard next state: clear on completion, then set on accepted issue
    always_comb begin
        pending_nxt = pending;
        if (mc_done) begin
            pending_nxt[mc_done_rd] = 1'b0;
        end
        if (acc_issue_c && (id_rd != '0)) begin
            pending_nxt[id_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;

        cnt_dec_c  = mc_done && (mc_cnt != '0);
        mc_cnt_nxt = mc_cnt;
        if (acc_issue_c && !cnt_dec_c) begin
            mc_cnt_nxt = mc_cnt + CNT_W'(1);
        end else if (!acc_issue_c && cnt_dec_c) begin
            mc_cnt_nxt = mc_cnt - CNT_W'(1);
        end
    end

    // Scoreboard and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            mc_cnt  <= '0;
            mc_busy <= 1'b0;
        end else begin
            pending <= pending_nxt;
            mc_cnt  <= mc_cnt_nxt;
            mc_busy <= (mc_cnt_nxt == CNT_W'(MC_DEPTH));
        end
    end

`ifdef FWD_HAZARD_STATS_EN
    logic any_fwd_c;
    logic any_mc_fwd_c;

    // Reduce the per-operand selects to per-cycle event flags
    always_comb begin
        any_fwd_c    = 1'b0;
        any_mc_fwd_c = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (fw_sel[i] != SEL_RF) begin
                any_fwd_c = 1'b1;
            end
            if (fw_sel[i] == SEL_MC) begin
                any_mc_fwd_c = 1'b1;
            end
        end
    end

    // Wrapping event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_stall_cyc  <= '0;
            stat_fwd_cnt    <= '0;
            stat_mc_fwd_cnt <= '0;
        end else begin
            stat_stall_cyc  <= stat_stall_cyc  + 32'(stall);
            stat_fwd_cnt    <= stat_fwd_cnt    + 32'(any_fwd_c);
            stat_mc_fwd_cnt <= stat_mc_fwd_cnt + 32'(any_mc_fwd_c);
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Testbench for fwd_hazard_unit: directed scenarios plus randomized traffic
// compared against a register-set / occupancy reference model.
module tb_fwd_hazard_unit;

    localparam int NS    = 2;
    localparam int AW    = 5;
    localparam int DEPTH = 4;

    logic                     clk;
    logic                     rst;
    logic [NS-1:0][AW-1:0]    id_rs;
    logic [NS-1:0]            id_rs_used;
    logic                     id_mc_issue;
    logic [AW-1:0]            id_rd;
    logic [AW-1:0]            id_ex_rd;
    logic                     id_ex_memread;
    logic [NS-1:0][AW-1:0]    ex_rs;
    logic [AW-1:0]            ex_mem_rd;
    logic                     ex_mem_regwrite;
    logic [AW-1:0]            mem_wb_rd;
    logic                     mem_wb_regwrite;
    logic                     mc_done;
    logic [AW-1:0]            mc_done_rd;
    logic [NS-1:0][1:0]       fw_sel;
    logic                     stall;
    logic                     mc_busy;
`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] stat_stall_cyc, stat_fwd_cnt, stat_mc_fwd_cnt;
    int unsigned m_st_stall, m_st_fwd, m_st_mc;
`endif

    fwd_hazard_unit #(.NUM_SRC(NS), .REG_AW(AW), .MC_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_mc_issue(id_mc_issue), .id_rd(id_rd),
        .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread),
        .ex_rs(ex_rs),
        .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite),
        .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
        .mc_done(mc_done), .mc_done_rd(mc_done_rd),
        .fw_sel(fw_sel), .stall(stall), .mc_busy(mc_busy)
`ifdef FWD_HAZARD_STATS_EN
        , .stat_stall_cyc(stat_stall_cyc), .stat_fwd_cnt(stat_fwd_cnt),
        .stat_mc_fwd_cnt(stat_mc_fwd_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: set of registers awaiting a multi-cycle result, and
    // the number of multi-cycle ops in flight.
    logic [31:0] m_pend;
    int          m_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_fw(input logic [AW-1:0] r);
        if (r == 0) return 2'd0;
        if (ex_mem_regwrite && ex_mem_rd == r) return 2'd2;
        if (mc_done && mc_done_rd == r) return 2'd3;
        if (mem_wb_regwrite && mem_wb_rd == r) return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit completing(input int r);
        return mc_done && (int'(mc_done_rd) == r);
    endfunction

    function automatic bit exp_stall();
        bit s;
        int r;
        s = 0;
        for (int i = 0; i < NS; i++) begin
            if (id_rs_used[i]) begin
                r = int'(id_rs[i]);
                if (id_ex_memread && id_ex_rd != 0 && int'(id_ex_rd) == r) s = 1;
                if (r != 0 && m_pend[r] && !completing(r)) s = 1;
            end
        end
        if (id_mc_issue && id_rd != 0 && m_pend[id_rd] && !completing(int'(id_rd))) s = 1;
        if (id_mc_issue && m_cnt == DEPTH && !mc_done) s = 1;
        return s;
    endfunction

    task automatic idle_inputs();
        id_rs = '0; id_rs_used = '0; id_mc_issue = 0; id_rd = '0;
        id_ex_rd = '0; id_ex_memread = 0; ex_rs = '0;
        ex_mem_rd = '0; ex_mem_regwrite = 0; mem_wb_rd = '0; mem_wb_regwrite = 0;
        mc_done = 0; mc_done_rd = '0;
    endtask

    task automatic model_clear();
        m_pend = '0;
        m_cnt  = 0;
`ifdef FWD_HAZARD_STATS_EN
        m_st_stall = 0; m_st_fwd = 0; m_st_mc = 0;
`endif
    endtask

    // Inputs are applied at the falling edge; check, clock, update, recheck.
    task automatic cycle();
        bit s, acc, any_f, any_m;
        logic [1:0] f;
        #2;
        any_f = 0; any_m = 0;
        for (int i = 0; i < NS; i++) begin
            f = exp_fw(ex_rs[i]);
            if (f != 0) any_f = 1;
            if (f == 3) any_m = 1;
            check($sformatf("fw_sel%0d", i), 64'(fw_sel[i]), 64'(f));
        end
        s = exp_stall();
        check("stall", 64'(stall), 64'(s));
        check("mc_busy", 64'(mc_busy), 64'(m_cnt == DEPTH));
        acc = id_mc_issue && !s;
        @(posedge clk);
        if (!rst) begin
            if (mc_done) m_pend[mc_done_rd] = 1'b0;
            if (acc && id_rd != 0) m_pend[id_rd] = 1'b1;
            if (acc && !(mc_done && m_cnt > 0)) m_cnt++;
            else if (!acc && mc_done && m_cnt > 0) m_cnt--;
`ifdef FWD_HAZARD_STATS_EN
            m_st_stall += int'(s); m_st_fwd += int'(any_f); m_st_mc += int'(any_m);
`endif
        end
        #1;
        check("pending", 64'(dut.pending), 64'(m_pend));
        check("mc_cnt", 64'(dut.mc_cnt), 64'(m_cnt));
        check("mc_busy_post", 64'(mc_busy), 64'(m_cnt == DEPTH));
        @(negedge clk);
    endtask

    task automatic issue(input int rd);
        idle_inputs();
        id_mc_issue = 1; id_rd = AW'(rd);
        cycle();
    endtask

    initial begin
        idle_inputs();
        model_clear();
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rst_busy", 64'(mc_busy), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_fw", 64'(fw_sel), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Forwarding priority on operand 0
        ex_rs[0] = 5'd7; ex_mem_rd = 5'd7; ex_mem_regwrite = 1;
        mem_wb_rd = 5'd7; mem_wb_regwrite = 1; mc_done = 1; mc_done_rd = 5'd7;
        #1 check("prio_exmem", 64'(fw_sel[0]), 64'd2);
        cycle();
        ex_mem_regwrite = 0;
        #1 check("prio_mc", 64'(fw_sel[0]), 64'd3);
        cycle();
        mc_done = 0;
        #1 check("prio_wb", 64'(fw_sel[0]), 64'd1);
        cycle();
        ex_rs[0] = 5'd0; ex_mem_rd = 5'd0; ex_mem_regwrite = 1; mem_wb_rd = 5'd0;
        #1 check("prio_x0", 64'(fw_sel[0]), 64'd0);
        cycle();

        // Load-use on operand 1
        idle_inputs();
        id_ex_memread = 1; id_ex_rd = 5'd3; id_rs[1] = 5'd3; id_rs_used = 2'b10;
        #1 check("load_use", 64'(stall), 64'd1);
        cycle();
        id_rs_used = 2'b00;
        #1 check("load_use_unused", 64'(stall), 64'd0);
        cycle();

        // Pending hazard and its same-cycle completion
        issue(9);
        idle_inputs();
        id_rs[0] = 5'd9; id_rs_used = 2'b01;
        #1 check("pend_haz", 64'(stall), 64'd1);
        cycle();
        mc_done = 1; mc_done_rd = 5'd9; ex_rs[0] = 5'd9;
        #1 check("pend_done_stall", 64'(stall), 64'd0);
        check("pend_done_fw", 64'(fw_sel[0]), 64'd3);
        cycle();

        // Occupancy limit
        for (int r = 1; r <= DEPTH; r++) issue(r);
        idle_inputs();
        #1 check("busy_full", 64'(mc_busy), 64'd1);
        id_mc_issue = 1; id_rd = 5'd5;
        #1 check("ovf_stall", 64'(stall), 64'd1);
        cycle();
        mc_done = 1; mc_done_rd = 5'd1;
        #1 check("ovf_done_accept", 64'(stall), 64'd0);
        cycle();
        check("ovf_cnt", 64'(dut.mc_cnt), 64'(DEPTH));

        // Same-index completion and reissue of x5
        idle_inputs();
        id_mc_issue = 1; id_rd = 5'd5; mc_done = 1; mc_done_rd = 5'd5;
        #1 check("same_idx_stall", 64'(stall), 64'd0);
        cycle();
        check("same_idx_pend", 64'(dut.pending[5]), 64'd1);
        check("same_idx_cnt", 64'(dut.mc_cnt), 64'(DEPTH));

        // Randomized traffic over a small register window to force collisions
        for (int n = 0; n < 3000; n++) begin
            idle_inputs();
            for (int i = 0; i < NS; i++) begin
                id_rs[i] = AW'($urandom_range(0, 7));
                ex_rs[i] = AW'($urandom_range(0, 7));
            end
            id_rs_used      = NS'($urandom);
            id_mc_issue     = ($urandom_range(0, 2) == 0);
            id_rd           = AW'($urandom_range(0, 7));
            id_ex_rd        = AW'($urandom_range(0, 7));
            id_ex_memread   = ($urandom_range(0, 3) == 0);
            ex_mem_rd       = AW'($urandom_range(0, 7));
            ex_mem_regwrite = $urandom_range(0, 1) == 1;
            mem_wb_rd       = AW'($urandom_range(0, 7));
            mem_wb_regwrite = $urandom_range(0, 1) == 1;
            mc_done         = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
            mc_done_rd      = AW'($urandom_range(0, 7));
            cycle();
        end

`ifdef FWD_HAZARD_STATS_EN
        check("stat_stall", 64'(stat_stall_cyc), 64'(m_st_stall));
        check("stat_fwd", 64'(stat_fwd_cnt), 64'(m_st_fwd));
        check("stat_mc", 64'(stat_mc_fwd_cnt), 64'(m_st_mc));
`endif

        // Asynchronous reset with ops in flight
        idle_inputs();
        rst = 1'b1;
        model_clear();
        cycle();
        rst = 1'b0;
        for (int r = 1; r <= 3; r++) issue(r);
        idle_inputs();
        id_rs[0] = 5'd2; id_rs_used = 2'b01;
        #2 check("pre_rst_stall", 64'(stall), 64'd1);
        rst = 1'b1;
        model_clear();
        #1;
        check("arst_stall", 64'(stall), 64'd0);
        check("arst_busy", 64'(mc_busy), 64'd0);
        check("arst_pend", 64'(dut.pending), 64'd0);
        check("arst_cnt", 64'(dut.mc_cnt), 64'd0);
`ifdef FWD_HAZARD_STATS_EN
        check("arst_stat0", 64'(stat_stall_cyc), 64'd0);
        check("arst_stat1", 64'(stat_fwd_cnt), 64'd0);
        check("arst_stat2", 64'(stat_mc_fwd_cnt), 64'd0);
`endif
        id_ex_memread = 1; id_ex_rd = 5'd6; id_rs[1] = 5'd6; id_rs_used = 2'b11;
        #1 check("arst_load_use", 64'(stall), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
